// File: rtl/multiples_fifo_ctrl.sv
// rtl/multiples_fifo_ctrl.sv - pointer/handshake controller for the 10-slot multiples array
module multiples_fifo_ctrl #(
  parameter int DEPTH      = 10,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_CNT  = ADDR_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  function automatic logic [ADDR_WIDTH-1:0] next_slot(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // The array decodes the write address as (addr-1) mod DEPTH, hence the +1 encoding.
  assign mem_write_enable  = push && !rst && !flush;
  assign mem_write_address = next_slot(wr_ptr);
  assign mem_write_data    = push_data;
  assign mem_read_address  = rd_ptr;
  assign pop_data          = mem_read_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_slot(wr_ptr);
      if (pop)  rd_ptr <= next_slot(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_valid && full) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multiples_fifo_ctrl.sv
// tb/tb_multiples_fifo_ctrl.sv - directed bench for multiples_fifo_ctrl with a behavioural array
module tb_multiples_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, push_valid, pop_ready;
  logic [2:0] push_data, pop_data, mem_write_data, mem_read_data;
  logic       push_ready, pop_valid, mem_write_enable, full, empty, overflow_err;
  logic [3:0] mem_write_address, mem_read_address, count;
  logic [2:0] mem [10];
  int         checks = 0;
  int         failures = 0;

  multiples_fifo_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data), .count(count), .full(full), .empty(empty),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Array model: write address decoded as (addr-1) mod 10, combinational read.
  always @(posedge clk) begin
    if (mem_write_enable)
      mem[(mem_write_address == 4'd0) ? 9 : int'(mem_write_address) - 1] <= mem_write_data;
  end
  always_comb begin
    mem_read_data = 3'd0;
    if (mem_read_address < 4'd10) mem_read_data = mem[int'(mem_read_address)];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = 3'd0;
    tick;
    rst = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%0b full=%0b exp=1/0", empty, full); end
    checks++; if (push_ready !== 1'b1 || pop_valid !== 1'b0) begin failures++; $display("FAIL reset_hs push_ready=%0b pop_valid=%0b exp=1/0", push_ready, pop_valid); end
    checks++; if (mem_write_address !== 4'd1 || mem_read_address !== 4'd0) begin failures++; $display("FAIL reset_addr wa=%0d ra=%0d exp=1/0", mem_write_address, mem_read_address); end
    checks++; if (overflow_err !== 1'b0 || mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_err ovf=%0b we=%0b exp=0/0", overflow_err, mem_write_enable); end
  endtask

  logic [2:0] fill_vals [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

  task automatic test_fill;
    for (int i = 0; i < 10; i++) begin
      push_valid = 1'b1; push_data = fill_vals[i];
      #1;
      checks++; if (mem_write_enable !== 1'b1 || mem_write_address !== ((i == 9) ? 4'd0 : 4'(i + 1))) begin
        failures++; $display("FAIL fill_waddr[%0d] we=%0b wa=%0d exp=1/%0d", i, mem_write_enable, mem_write_address, (i == 9) ? 0 : i + 1);
      end
      tick;
      checks++; if (count !== 4'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    push_valid = 1'b0;
    #1;
    checks++; if (full !== 1'b1 || push_ready !== 1'b0) begin failures++; $display("FAIL fill_full full=%0b push_ready=%0b exp=1/0", full, push_ready); end
    push_valid = 1'b1; push_data = 3'd3;
    #1;
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL overflow_we got=%0b exp=0", mem_write_enable); end
    tick;
    push_valid = 1'b0;
    #1;
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL overflow_err got=%0b exp=1", overflow_err); end
    checks++; if (count !== 4'd10 || mem_write_address !== 4'd1) begin failures++; $display("FAIL overflow_hold count=%0d wa=%0d exp=10/1", count, mem_write_address); end
  endtask

  task automatic test_drain;
    pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (pop_valid !== 1'b1 || pop_data !== fill_vals[i] || mem_read_address !== 4'(i)) begin
        failures++; $display("FAIL drain[%0d] valid=%0b data=%0d ra=%0d exp=1/%0d/%0d", i, pop_valid, pop_data, mem_read_address, fill_vals[i], i);
      end
      tick;
    end
    pop_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || pop_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL drain_empty empty=%0b valid=%0b count=%0d exp=1/0/0", empty, pop_valid, count); end
    checks++; if (mem_read_address !== 4'd0) begin failures++; $display("FAIL drain_rdwrap got=%0d exp=0", mem_read_address); end
  endtask

  task automatic test_wrap_stream;
    for (int k = 0; k < 3; k++) begin
      push_valid = 1'b1; push_data = 3'(k);
      tick;
    end
    for (int j = 0; j < 25; j++) begin
      push_valid = 1'b1; push_data = 3'(j + 3); pop_ready = 1'b1;
      #1;
      checks++; if (pop_valid !== 1'b1 || pop_data !== 3'(j)) begin failures++; $display("FAIL wrap_data[%0d] valid=%0b data=%0d exp=1/%0d", j, pop_valid, pop_data, j & 7); end
      tick;
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=3", j, count); end
    end
    push_valid = 1'b0;
    #1;
    checks++; if (mem_read_address !== 4'd5 || mem_write_address !== 4'd9) begin failures++; $display("FAIL wrap_ptrs ra=%0d wa=%0d exp=5/9", mem_read_address, mem_write_address); end
    for (int k = 25; k < 28; k++) begin
      #1;
      checks++; if (pop_data !== 3'(k)) begin failures++; $display("FAIL wrap_tail[%0d] got=%0d exp=%0d", k, pop_data, k & 7); end
      tick;
    end
    pop_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_latency;
    pop_ready = 1'b1;
    tick;
    checks++; if (count !== 4'd0 || mem_read_address !== 4'd8) begin failures++; $display("FAIL empty_pop_ignored count=%0d ra=%0d exp=0/8", count, mem_read_address); end
    pop_ready = 1'b0;
    push_valid = 1'b1; push_data = 3'd5;
    #1;
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL latency_same_cycle valid=%0b exp=0", pop_valid); end
    tick;
    push_valid = 1'b0;
    #1;
    checks++; if (pop_valid !== 1'b1 || pop_data !== 3'd5) begin failures++; $display("FAIL latency_next valid=%0b data=%0d exp=1/5", pop_valid, pop_data); end
    pop_ready = 1'b1;
    tick;
    pop_ready = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL latency_pop empty=%0b exp=1", empty); end
  endtask

  task automatic test_flush;
    for (int k = 0; k < 6; k++) begin
      push_valid = 1'b1; push_data = 3'(6 - k);
      tick;
    end
    checks++; if (count !== 4'd6) begin failures++; $display("FAIL flush_pre count=%0d exp=6", count); end
    flush = 1'b1; push_valid = 1'b1; push_data = 3'd7;
    #1;
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL flush_we got=%0b exp=0", mem_write_enable); end
    tick;
    flush = 1'b0; push_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL flush_count count=%0d empty=%0b exp=0/1", count, empty); end
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL flush_ovf_kept got=%0b exp=1", overflow_err); end
    checks++; if (mem_read_address !== 4'd0 || mem_write_address !== 4'd1) begin failures++; $display("FAIL flush_ptrs ra=%0d wa=%0d exp=0/1", mem_read_address, mem_write_address); end
    push_valid = 1'b1; push_data = 3'd4;
    tick;
    push_valid = 1'b0;
    #1;
    checks++; if (pop_valid !== 1'b1 || pop_data !== 3'd4) begin failures++; $display("FAIL flush_repush valid=%0b data=%0d exp=1/4", pop_valid, pop_data); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_wrap_stream;
    test_latency;
    test_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
